mem_control: RTL and testbench
==============================

# mem_control

Memory-side responder for the CPU core's instruction-fetch and MEM-stage data ports. It owns a single external asynchronous SRAM and arbitrates between the fetch and data paths, with data always winning. It serialises each data access through a small state machine and raises a pause request while the fetch slot is taken. It sits between the CPU top level and the board SRAM pins.

## Interface
- DATA_W, 16, CPU word width and SRAM data width
- ADDR_W, 16, CPU word-address width
- RAM_ADDR_W, 18, SRAM address width; CPU addresses are zero-extended
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- inst_addr_i  in  ADDR_W  fetch address (PC)
- inst_en_i  in  1  fetch enable
- inst_data_o  out  DATA_W  fetched instruction, combinational from SRAM
- mem_addr_i  in  ADDR_W  MEM-stage data address
- mem_wdata_i  in  DATA_W  MEM-stage store data
- mem_re_i  in  1  MEM-stage load request
- mem_we_i  in  1  MEM-stage store request
- mem_rdata_o  out  DATA_W  load result, registered
- pause_o  out  1  pipeline pause request to ctrl
- ram_addr_o  out  RAM_ADDR_W  SRAM address
- ram_data_i  in  DATA_W  SRAM read data
- ram_data_o  out  DATA_W  SRAM write data
- ram_data_oe_o  out  1  drive enable for the SRAM data pins; tristate is at the board top
- ram_ce_n_o, ram_oe_n_o, ram_we_n_o  out  1 each  SRAM strobes, active-low

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, RELEASE.
- IDLE, no request:
  - Fetch path: ram_addr_o = inst_addr_i, ce_n=0, oe_n=0, we_n=1, oe=0.
  - inst_data_o = ram_data_i.
  - If inst_en_i=0: ce_n=1 and inst_data_o=0.
- IDLE, request present:
  - mem_we_i=1 goes to WR_SETUP. It takes priority if both are set; the load is dropped and mem_rdata_o=0.
  - Otherwise mem_re_i=1 goes to RD.
  - The decision is combinational in IDLE, so the first access cycle is that same IDLE cycle (see below).
- Load, 2 cycles:
  - Cycle A (IDLE with mem_re_i): ram_addr_o = mem_addr_i, oe_n=0, pause_o=1, inst_data_o=0. At the edge, ram_data_i is captured into mem_rdata_o and the state becomes RELEASE.
  - The RD state name is reserved and is unused as a dwell state.
- Store, 4 cycles:
  - Cycle A (IDLE with mem_we_i): addr and data driven, oe=1, oe_n=1, we_n=1, pause_o=1. Next state WR_PULSE.
  - WR_PULSE: we_n=0, pause_o=1. Next state WR_HOLD.
  - WR_HOLD: we_n=1, data still driven, pause_o=1. Next state RELEASE.
  - Address and data are latched at cycle A. They stay stable through WR_HOLD even if the inputs change.
- RELEASE:
  - pause_o=0 and the fetch path is active as in IDLE, so the stalled pipeline advances at this edge.
  - The request still visible on the mem_* inputs is not re-executed.
  - Next state is always IDLE.
- pause_o is 1 in cycle A, WR_PULSE and WR_HOLD. It is 0 in IDLE-without-request and in RELEASE.
- mem_rdata_o holds its last loaded value until the next load completes.
- ID-stage stalls do not freeze MEM, so a persistent request after RELEASE is always a new instruction. Back-to-back accesses are legal: IDLE→...→RELEASE→IDLE(new A).

## Timing
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE, mem_rdata_o=0, latched addr/data=0.
  - Strobes go high at that edge: we_n=1, oe=0, pause_o=0.
  - This applies mid-write as well; WR_PULSE is aborted with we_n high the cycle after the edge.
- While rst=1: ce_n=1, oe_n=1, we_n=1, inst_data_o=0, pause_o=0.
- Fetch latency: 0 cycles (combinational through async SRAM).
- Load: pause for 1 cycle; data is valid in mem_rdata_o during RELEASE (1 cycle after request).
- Store: pause for 3 cycles. we_n low for exactly 1 cycle, with address/data stable for one cycle before and after the pulse.
- we_n and oe_n are never low simultaneously. oe=1 only in store cycle A, WR_PULSE and WR_HOLD.

## Test plan
- Fetch only: SRAM[0x0010]=0x4A05, inst_addr_i=0x0010, no mem request -> inst_data_o=0x4A05 same cycle, pause_o=0 every cycle.
- Load: SRAM[0x8000]=0x1234, mem_re_i=1 at 0x8000 -> pause_o=1 for one cycle, then RELEASE with mem_rdata_o=0x1234, pause_o=0, fetch resumes.
- Store: mem_we_i=1, addr 0x9001, data 0xBEEF, inputs changed to garbage after cycle A -> we_n low exactly in cycle 2, pause_o=1 for cycles 1-3, SRAM[0x9001]=0xBEEF, read-back load returns 0xBEEF.
- Simultaneous re/we at 0x0200 with data 0x5555 -> store executes, SRAM[0x0200]=0x5555, mem_rdata_o=0.
- Back-to-back: store 0x00A0←0x0001 immediately followed by a load 0x00A0 -> sequence A,PULSE,HOLD,RELEASE,A,RELEASE; load returns 0x0001, pause_o deasserted only in the two RELEASE cycles.
- Reset during WR_PULSE -> next cycle state IDLE, we_n=1, oe=0, pause_o=0, mem_rdata_o=0.

Source files
------------

// File: rtl/mem_control_if.sv
// mem_control_if: CPU-side and SRAM-side signal bundle for mem_control.
//   CPU side : inst_addr_i, inst_en_i, inst_data_o (fetch port)
//              mem_addr_i, mem_wdata_i, mem_re_i, mem_we_i, mem_rdata_o (MEM-stage port)
//              pause_o (pipeline pause request)
//   SRAM side: ram_addr_o, ram_data_i, ram_data_o, ram_data_oe_o,
//              ram_ce_n_o, ram_oe_n_o, ram_we_n_o (active-low strobes)
// Modports: slave = mem_control itself, master = whatever drives the CPU inputs and SRAM read data.
interface mem_control_if #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned RAM_ADDR_W = 18
);
    logic [ADDR_W-1:0]     inst_addr_i;
    logic                  inst_en_i;
    logic [DATA_W-1:0]     inst_data_o;
    logic [ADDR_W-1:0]     mem_addr_i;
    logic [DATA_W-1:0]     mem_wdata_i;
    logic                  mem_re_i;
    logic                  mem_we_i;
    logic [DATA_W-1:0]     mem_rdata_o;
    logic                  pause_o;
    logic [RAM_ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0]     ram_data_i;
    logic [DATA_W-1:0]     ram_data_o;
    logic                  ram_data_oe_o;
    logic                  ram_ce_n_o;
    logic                  ram_oe_n_o;
    logic                  ram_we_n_o;

    modport slave (
        input  inst_addr_i, inst_en_i, mem_addr_i, mem_wdata_i, mem_re_i, mem_we_i, ram_data_i,
        output inst_data_o, mem_rdata_o, pause_o, ram_addr_o, ram_data_o, ram_data_oe_o,
               ram_ce_n_o, ram_oe_n_o, ram_we_n_o
    );

    modport master (
        output inst_addr_i, inst_en_i, mem_addr_i, mem_wdata_i, mem_re_i, mem_we_i, ram_data_i,
        input  inst_data_o, mem_rdata_o, pause_o, ram_addr_o, ram_data_o, ram_data_oe_o,
               ram_ce_n_o, ram_oe_n_o, ram_we_n_o
    );
endinterface

// File: rtl/mem_control.sv
// mem_control: single async-SRAM responder shared by instruction fetch and MEM-stage data.
// Data accesses win over fetch; while one is in flight the pipeline is paused.
//   clk  : system clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_control_if.slave (CPU fetch/data ports, pause, SRAM pins)
// Load  = 2 cycles (access in IDLE, then RELEASE); store = 4 cycles
// (setup in IDLE, WR_PULSE, WR_HOLD, RELEASE).
module mem_control #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned RAM_ADDR_W = 18
) (
    input logic         clk,
    input logic         rst,
    mem_control_if.slave bus
);

    // StRd and StWrSetup are never entered: the first access cycle of a load
    // or store is the IDLE cycle in which the request is seen.
    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StRelease
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.mem_we_i) begin
                        // Latch so the inputs may change during the pulse/hold beats.
                        addr_q  <= bus.mem_addr_i;
                        wdata_q <= bus.mem_wdata_i;
                        state_q <= StWrPulse;
                        // A load issued together with a store is dropped and reads as 0.
                        if (bus.mem_re_i) rdata_q <= '0;
                    end else if (bus.mem_re_i) begin
                        rdata_q <= bus.ram_data_i;
                        state_q <= StRelease;
                    end
                end
                StWrPulse: state_q <= StWrHold;
                StWrHold:  state_q <= StRelease;
                default:   state_q <= StIdle;
            endcase
        end
    end

    assign bus.mem_rdata_o = rdata_q;

    always_comb begin
        bus.ram_addr_o    = RAM_ADDR_W'(bus.inst_addr_i);
        bus.ram_data_o    = '0;
        bus.ram_data_oe_o = 1'b0;
        bus.ram_ce_n_o    = 1'b1;
        bus.ram_oe_n_o    = 1'b1;
        bus.ram_we_n_o    = 1'b1;
        bus.pause_o       = 1'b0;
        bus.inst_data_o   = '0;
        if (!rst) begin
            if (state_q == StWrPulse || state_q == StWrHold) begin
                bus.ram_addr_o    = RAM_ADDR_W'(addr_q);
                bus.ram_data_o    = wdata_q;
                bus.ram_data_oe_o = 1'b1;
                bus.ram_ce_n_o    = 1'b0;
                bus.ram_we_n_o    = (state_q != StWrPulse);
                bus.pause_o       = 1'b1;
            end else if (state_q == StIdle && bus.mem_we_i) begin
                // Store setup beat: address and data settle before the pulse.
                bus.ram_addr_o    = RAM_ADDR_W'(bus.mem_addr_i);
                bus.ram_data_o    = bus.mem_wdata_i;
                bus.ram_data_oe_o = 1'b1;
                bus.ram_ce_n_o    = 1'b0;
                bus.pause_o       = 1'b1;
            end else if (state_q == StIdle && bus.mem_re_i) begin
                bus.ram_addr_o = RAM_ADDR_W'(bus.mem_addr_i);
                bus.ram_ce_n_o = 1'b0;
                bus.ram_oe_n_o = 1'b0;
                bus.pause_o    = 1'b1;
            end else begin
                // Fetch path: IDLE without request, RELEASE (request ignored).
                bus.ram_ce_n_o  = ~bus.inst_en_i;
                bus.ram_oe_n_o  = 1'b0;
                bus.inst_data_o = bus.inst_en_i ? bus.ram_data_i : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_control.sv
// tb_mem_control: directed test-plan scenarios followed by random traffic, all
// checked every cycle against a transaction-level model with a shadow memory.
module tb_mem_control;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_control_if #(.DATA_W(16), .ADDR_W(16), .RAM_ADDR_W(18)) bus ();

    mem_control #(.DATA_W(16), .ADDR_W(16), .RAM_ADDR_W(18)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        logic [31:0] v;
        v = i * 32'h9E37;
        if (i == 16'h0010) return 16'h4A05;
        if (i == 16'h8000) return 16'h1234;
        return v[15:0] ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Board SRAM: asynchronous read, write committed on a low we_n strobe.
    logic [15:0] sram [65536];
    assign bus.ram_data_i = sram[bus.ram_addr_o[15:0]];

    initial begin
        logic [15:0] wa;
        logic [15:0] wd;
        for (int i = 0; i < 65536; i++) sram[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (!bus.ram_ce_n_o && !bus.ram_we_n_o && bus.ram_data_oe_o) begin
                wa = bus.ram_addr_o[15:0];
                wd = bus.ram_data_o;
                #1;
                sram[wa] = wd;
            end
        end
    end

    // Transaction model: remaining store beats, release pending, latched store, load result.
    logic [15:0] exp_mem [65536];
    bit          m_known;
    int          m_wr_left;
    bit          m_rel;
    logic [15:0] m_addr;
    logic [15:0] m_data;
    logic [15:0] m_rdata;

    initial begin
        for (int i = 0; i < 65536; i++) exp_mem[i] = init_val(i);
        m_known = 0; m_wr_left = 0; m_rel = 0; m_addr = '0; m_data = '0; m_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ce_n", bus.ram_ce_n_o, 1);
                chk("rst_oe_n", bus.ram_oe_n_o, 1);
                chk("rst_we_n", bus.ram_we_n_o, 1);
                chk("rst_oe", bus.ram_data_oe_o, 0);
                chk("rst_pause", bus.pause_o, 0);
                chk("rst_inst", bus.inst_data_o, 0);
                m_known = 1; m_wr_left = 0; m_rel = 0; m_rdata = '0;
            end else if (m_known) begin
                chk("rdata", bus.mem_rdata_o, m_rdata);
                chk("we_oe_overlap", {31'd0, bus.ram_we_n_o | bus.ram_oe_n_o}, 1);
                if (m_wr_left > 0) begin
                    chk("st_addr", bus.ram_addr_o, {2'b00, m_addr});
                    chk("st_data", bus.ram_data_o, m_data);
                    chk("st_oe", bus.ram_data_oe_o, 1);
                    chk("st_ce_n", bus.ram_ce_n_o, 0);
                    chk("st_oe_n", bus.ram_oe_n_o, 1);
                    chk("st_we_n", bus.ram_we_n_o, (m_wr_left == 2) ? 0 : 1);
                    chk("st_pause", bus.pause_o, 1);
                    chk("st_inst", bus.inst_data_o, 0);
                    if (m_wr_left == 2) exp_mem[m_addr] = m_data;
                    m_wr_left--;
                    if (m_wr_left == 0) m_rel = 1;
                end else if (m_rel || !(bus.mem_we_i || bus.mem_re_i)) begin
                    chk("f_addr", bus.ram_addr_o, {2'b00, bus.inst_addr_i});
                    chk("f_ce_n", bus.ram_ce_n_o, {31'd0, ~bus.inst_en_i});
                    chk("f_oe_n", bus.ram_oe_n_o, 0);
                    chk("f_we_n", bus.ram_we_n_o, 1);
                    chk("f_oe", bus.ram_data_oe_o, 0);
                    chk("f_pause", bus.pause_o, 0);
                    chk("f_inst", bus.inst_data_o,
                        bus.inst_en_i ? exp_mem[bus.inst_addr_i] : 16'h0);
                    m_rel = 0;
                end else if (bus.mem_we_i) begin
                    chk("sa_addr", bus.ram_addr_o, {2'b00, bus.mem_addr_i});
                    chk("sa_data", bus.ram_data_o, bus.mem_wdata_i);
                    chk("sa_oe", bus.ram_data_oe_o, 1);
                    chk("sa_ce_n", bus.ram_ce_n_o, 0);
                    chk("sa_oe_n", bus.ram_oe_n_o, 1);
                    chk("sa_we_n", bus.ram_we_n_o, 1);
                    chk("sa_pause", bus.pause_o, 1);
                    chk("sa_inst", bus.inst_data_o, 0);
                    m_addr = bus.mem_addr_i;
                    m_data = bus.mem_wdata_i;
                    m_wr_left = 2;
                    if (bus.mem_re_i) m_rdata = '0;
                end else begin
                    chk("ld_addr", bus.ram_addr_o, {2'b00, bus.mem_addr_i});
                    chk("ld_ce_n", bus.ram_ce_n_o, 0);
                    chk("ld_oe_n", bus.ram_oe_n_o, 0);
                    chk("ld_we_n", bus.ram_we_n_o, 1);
                    chk("ld_oe", bus.ram_data_oe_o, 0);
                    chk("ld_pause", bus.pause_o, 1);
                    chk("ld_inst", bus.inst_data_o, 0);
                    m_rdata = exp_mem[bus.mem_addr_i];
                    m_rel = 1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] pat;
        int         bad;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.inst_addr_i = '0; bus.inst_en_i = 1'b0;
        bus.mem_addr_i = '0; bus.mem_wdata_i = '0; bus.mem_re_i = 1'b0; bus.mem_we_i = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;

        // Fetch only
        bus.inst_addr_i = 16'h0010; bus.inst_en_i = 1'b1;
        @(negedge clk);
        chk("fetch_data", bus.inst_data_o, 16'h4A05);
        chk("fetch_pause", bus.pause_o, 0);
        cyc();

        // Load 0x8000
        bus.mem_addr_i = 16'h8000; bus.mem_re_i = 1'b1;
        @(negedge clk);
        chk("load_a_pause", bus.pause_o, 1);
        cyc();
        @(negedge clk);
        chk("load_rel_pause", bus.pause_o, 0);
        chk("load_rel_rdata", bus.mem_rdata_o, 16'h1234);
        chk("load_rel_fetch", bus.inst_data_o, 16'h4A05);
        cyc();
        bus.mem_re_i = 1'b0;

        // Store 0x9001 <- 0xBEEF, inputs scrambled after the setup beat
        bus.mem_addr_i = 16'h9001; bus.mem_wdata_i = 16'hBEEF; bus.mem_we_i = 1'b1;
        @(negedge clk);
        chk("store1_pause", bus.pause_o, 1);
        chk("store1_we_n", bus.ram_we_n_o, 1);
        cyc();
        bus.mem_addr_i = 16'h1357; bus.mem_wdata_i = 16'h2468;
        @(negedge clk);
        chk("store2_we_n", bus.ram_we_n_o, 0);
        chk("store2_addr", bus.ram_addr_o, 18'h09001);
        chk("store2_data", bus.ram_data_o, 16'hBEEF);
        cyc();
        @(negedge clk);
        chk("store3_we_n", bus.ram_we_n_o, 1);
        chk("store3_pause", bus.pause_o, 1);
        cyc();
        @(negedge clk);
        chk("store4_pause", bus.pause_o, 0);
        cyc();
        bus.mem_we_i = 1'b0;
        bus.mem_addr_i = 16'h9001; bus.mem_re_i = 1'b1;
        cyc();
        @(negedge clk);
        chk("readback", bus.mem_rdata_o, 16'hBEEF);
        chk("sram_9001", sram[16'h9001], 16'hBEEF);
        cyc();

        // Simultaneous load and store
        bus.mem_addr_i = 16'h0200; bus.mem_wdata_i = 16'h5555;
        bus.mem_re_i = 1'b1; bus.mem_we_i = 1'b1;
        repeat (4) cyc();
        bus.mem_re_i = 1'b0; bus.mem_we_i = 1'b0;
        @(negedge clk);
        chk("both_rdata", bus.mem_rdata_o, 0);
        chk("both_sram", sram[16'h0200], 16'h5555);
        cyc();

        // Back-to-back store then load
        bus.mem_addr_i = 16'h00A0; bus.mem_wdata_i = 16'h0001; bus.mem_we_i = 1'b1;
        pat = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pat[k] = bus.pause_o;
            if (k == 5) chk("b2b_rdata", bus.mem_rdata_o, 16'h0001);
            cyc();
            if (k == 3) begin
                bus.mem_we_i = 1'b0; bus.mem_re_i = 1'b1;
            end
        end
        bus.mem_re_i = 1'b0;
        chk("b2b_pause", {26'd0, pat}, 32'h17);

        // Reset while the write pulse is due
        bus.mem_addr_i = 16'h0300; bus.mem_wdata_i = 16'h7777; bus.mem_we_i = 1'b1;
        cyc();
        rst = 1'b1; bus.mem_we_i = 1'b0;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_we_n", bus.ram_we_n_o, 1);
        chk("rstw_oe", bus.ram_data_oe_o, 0);
        chk("rstw_pause", bus.pause_o, 0);
        chk("rstw_rdata", bus.mem_rdata_o, 0);
        chk("rstw_sram", sram[16'h0300], 16'hFF5A);
        cyc();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            bus.inst_addr_i = 16'($urandom);
            bus.inst_en_i   = ($urandom_range(0, 7) != 0);
            bus.mem_addr_i  = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                          : 16'($urandom_range(0, 31));
            bus.mem_wdata_i = 16'($urandom);
            bus.mem_re_i    = ($urandom_range(0, 2) == 0);
            bus.mem_we_i    = ($urandom_range(0, 3) == 0);
            rst             = ($urandom_range(0, 79) == 0);
            cyc();
        end
        rst = 1'b0; bus.mem_re_i = 1'b0; bus.mem_we_i = 1'b0;
        repeat (5) cyc();

        bad = 0;
        for (int i = 0; i < 65536; i++) if (sram[i] !== exp_mem[i]) bad++;
        chk("mem_sweep", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
